force_ring_stop: RTL

- Parametrised, self-contained ring stop for the force-return ring, one instance per cell.
- Neighbour-force packets leaving the local PE enter an injection FIFO and are merged onto a stallable ring.
- Ring packets addressed to this cell are ejected to the force cache; all other ring packets are forwarded.
- Adds what the previous ring node lacks: downstream back-pressure, a hop-count TTL that drops orphans, and anti-starvation injection.

---
 rtl/force_ring_stop.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/force_ring_stop.sv
// force_ring_stop: one ring stop of the force-return ring.
// Local neighbour-force packets queue in an injection FIFO and are merged onto
// a stallable ring. Ring packets addressed to this cell go to the force cache;
// others are forwarded with an incremented hop count, or dropped once the hop
// count reaches MAX_HOPS. A starvation counter forces injection when upstream
// traffic keeps the ring slot busy for too long.
//
// Handshakes: the injection port accepts a packet on any cycle where
// i_inj_valid && o_inj_ready. The ring uses valid/stall: a packet is taken
// on a cycle where valid is high and stall is low; while stall is high the
// sender holds the same packet. The cache port is valid-only and never stalls.
module force_ring_stop #(
  parameter int FORCE_W      = 96,
  parameter int PARID_W      = 8,
  parameter int GCID_W       = 2,
  parameter int GCELL_X      = 0,
  parameter int GCELL_Y      = 0,
  parameter int GCELL_Z      = 0,
  parameter int FIFO_DEPTH   = 8,
  parameter int HOP_W        = 6,
  parameter int MAX_HOPS     = 40,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FORCE_W-1:0]            i_inj_force,
  input  logic [PARID_W-1:0]            i_inj_parid,
  input  logic [3*GCID_W-1:0]           i_inj_gcid,
  input  logic                          i_inj_valid,
  output logic                          o_inj_ready,
  input  logic [FORCE_W-1:0]            i_ring_force,
  input  logic [PARID_W-1:0]            i_ring_parid,
  input  logic [3*GCID_W-1:0]           i_ring_gcid,
  input  logic [HOP_W-1:0]              i_ring_hops,
  input  logic                          i_ring_valid,
  output logic                          o_ring_stall,
  output logic [FORCE_W-1:0]            o_ring_force,
  output logic [PARID_W-1:0]            o_ring_parid,
  output logic [3*GCID_W-1:0]           o_ring_gcid,
  output logic [HOP_W-1:0]              o_ring_hops,
  output logic                          o_ring_valid,
  input  logic                          i_ring_stall,
  output logic [FORCE_W-1:0]            o_cache_force,
  output logic [PARID_W-1:0]            o_cache_parid,
  output logic                          o_cache_valid,
  output logic                          o_fifo_empty,
  output logic                          o_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_drop_err,
  output logic                          o_ovf_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = 3 * GCID_W;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int PW = FORCE_W + PARID_W + GW;

  localparam logic [GW-1:0]    MY_GCID   = {GCID_W'(GCELL_X), GCID_W'(GCELL_Y), GCID_W'(GCELL_Z)};
  localparam logic [HOP_W:0]   HOP_LIMIT = (HOP_W + 1)'(MAX_HOPS);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  // Injection FIFO storage and bookkeeping
  logic [PW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [SW-1:0]  starve_cnt;

  logic [PW-1:0]      head;
  logic [FORCE_W-1:0] head_force;
  logic [PARID_W-1:0] head_parid;
  logic [GW-1:0]      head_gcid;
  logic               head_local;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;

  // Ring datapath decisions
  logic           in_match;
  logic [HOP_W:0] hops_next;
  logic           ttl_expired;
  logic           hold;
  logic           force_inj;
  logic           in_take;
  logic           ring_eject;
  logic           drop;
  logic           fwd;
  logic           pop_ring;
  logic           pop_local;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign head       = mem[rd_ptr];
  assign head_force = head[PW-1 -: FORCE_W];
  assign head_parid = head[GW +: PARID_W];
  assign head_gcid  = head[GW-1:0];
  assign head_local = (head_gcid == MY_GCID);

  assign o_inj_ready  = !fifo_full && !rst;
  assign o_fifo_empty = fifo_empty;
  assign o_fifo_full  = fifo_full;
  assign o_fifo_count = count;

  assign push = i_inj_valid && o_inj_ready;
  assign pop  = pop_ring || pop_local;

  assign in_match    = (i_ring_gcid == MY_GCID);
  assign hops_next   = {1'b0, i_ring_hops} + {{HOP_W{1'b0}}, 1'b1};
  assign ttl_expired = (hops_next >= HOP_LIMIT);

  // A full, stalled output register freezes the whole stop.
  assign hold = i_ring_stall && o_ring_valid;

  // Forced injection stalls upstream for one cycle so a starved non-local
  // head can claim the slot that a forwarded packet would otherwise take.
  assign force_inj = (starve_cnt == STARVE_MAX) && !fifo_empty && !head_local &&
                     i_ring_valid && !in_match;

  assign o_ring_stall = hold || force_inj;
  assign in_take      = i_ring_valid && !o_ring_stall;

  // Per-cycle slot arbitration: ring ejection, TTL drop, forward, then FIFO.
  always_comb begin
    ring_eject = 1'b0;
    drop       = 1'b0;
    fwd        = 1'b0;
    pop_ring   = 1'b0;
    pop_local  = 1'b0;
    if (!hold) begin
      if (in_take && in_match) begin
        ring_eject = 1'b1;
      end else if (in_take && ttl_expired) begin
        drop = 1'b1;
      end else if (in_take) begin
        fwd = 1'b1;
      end
      if (!fwd && !fifo_empty && !head_local) begin
        pop_ring = 1'b1;
      end
      if (!ring_eject && !fifo_empty && head_local) begin
        pop_local = 1'b1;
      end
    end
  end

  // FIFO storage write; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {i_inj_force, i_inj_parid, i_inj_gcid};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Starvation counter: counts queued cycles without a pop, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pop) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Ring output register: forward, inject the FIFO head, or go empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ring_valid <= 1'b0;
      o_ring_force <= '0;
      o_ring_parid <= '0;
      o_ring_gcid  <= '0;
      o_ring_hops  <= '0;
    end else if (!hold) begin
      if (fwd) begin
        o_ring_valid <= 1'b1;
        o_ring_force <= i_ring_force;
        o_ring_parid <= i_ring_parid;
        o_ring_gcid  <= i_ring_gcid;
        o_ring_hops  <= hops_next[HOP_W-1:0];
      end else if (pop_ring) begin
        o_ring_valid <= 1'b1;
        o_ring_force <= head_force;
        o_ring_parid <= head_parid;
        o_ring_gcid  <= head_gcid;
        o_ring_hops  <= '0;
      end else begin
        o_ring_valid <= 1'b0;
      end
    end
  end

  // Cache ejection register: ring packet wins, local FIFO head otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cache_valid <= 1'b0;
      o_cache_force <= '0;
      o_cache_parid <= '0;
    end else if (ring_eject) begin
      o_cache_valid <= 1'b1;
      o_cache_force <= i_ring_force;
      o_cache_parid <= i_ring_parid;
    end else if (pop_local) begin
      o_cache_valid <= 1'b1;
      o_cache_force <= head_force;
      o_cache_parid <= head_parid;
    end else begin
      o_cache_valid <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      o_drop_err <= 1'b0;
      o_ovf_err  <= 1'b0;
    end else begin
      if (drop) begin
        o_drop_err <= 1'b1;
      end
      if (i_inj_valid && fifo_full) begin
        o_ovf_err <= 1'b1;
      end
    end
  end

endmodule
